// File: rtl/sawtooth_ctrl.sv
// Programmable sawtooth / triangle generator with run, pause and period-count control.
// val, wrap and done are registered; busy and cfg_ready decode the state register only.
module sawtooth_ctrl #(
   parameter int LEN = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [1:0] cfg_mode,
   input  logic [7:0] cfg_max,
   input  logic [7:0] cfg_cycles,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   output logic [7:0] val,
   output logic       busy,
   output logic       wrap,
   output logic       done
);

   localparam int PW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [PW-1:0] PLAST = PW'(LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] presc, presc_nx;
   logic [7:0]    val_nx, pcnt, pcnt_nx;
   logic [7:0]    max_r, max_nx, cyc_r, cyc_nx;
   logic [1:0]    mode_r, mode_nx;
   logic          dir_dn, dir_nx, wrap_nx, done_nx;
   logic          tick, step_wrap, step_dir;
   logic [7:0]    step_val;

   // One waveform step: returns {wrap, direction_down, next value}.
   function automatic logic [9:0] wave_step(input logic [1:0] m, input logic [7:0] v,
                                            input logic [7:0] mx, input logic dn);
      logic [7:0] nv;
      logic       nd, w;
      nv = v;
      nd = dn;
      w  = 1'b0;
      if (mx == 8'd0) begin
         nv = 8'd0;
         nd = 1'b0;
         w  = 1'b1;
      end else if (m == 2'b01) begin
         if (v != 8'd0) nv = v - 8'd1;
         else begin
            nv = mx;
            w  = 1'b1;
         end
      end else if (m == 2'b10) begin
         if (!dn) begin
            if (v < mx) nv = v + 8'd1;
            else begin
               nd = 1'b1;
               nv = v - 8'd1;
            end
         end else begin
            if (v != 8'd0) nv = v - 8'd1;
            else begin
               nd = 1'b0;
               nv = v + 8'd1;
               w  = 1'b1;
            end
         end
      end else begin
         if (v < mx) nv = v + 8'd1;
         else begin
            nv = 8'd0;
            w  = 1'b1;
         end
      end
      return {w, nd, nv};
   endfunction

   always_comb begin
      state_nx = state;
      presc_nx = presc;
      val_nx   = val;
      pcnt_nx  = pcnt;
      dir_nx   = dir_dn;
      mode_nx  = mode_r;
      max_nx   = max_r;
      cyc_nx   = cyc_r;
      wrap_nx  = 1'b0;
      done_nx  = 1'b0;
      tick     = (presc == PLAST);
      {step_wrap, step_dir, step_val} = wave_step(mode_r, val, max_r, dir_dn);
      case (state)
         IDLE: begin
            // Same-cycle accept and start must launch with the new config.
            if (cfg_valid) begin
               mode_nx = cfg_mode;
               max_nx  = cfg_max;
               cyc_nx  = cfg_cycles;
            end
            if (start) begin
               state_nx = RUN;
               presc_nx = '0;
               pcnt_nx  = 8'd0;
               dir_nx   = 1'b0;
               val_nx   = (mode_nx == 2'b01) ? max_nx : 8'd0;
            end
         end
         RUN: begin
            if (stop) begin
               state_nx = IDLE;
               val_nx   = 8'd0;
               presc_nx = '0;
            end else begin
               presc_nx = tick ? '0 : presc + 1'b1;
               if (tick) begin
                  val_nx  = step_val;
                  dir_nx  = step_dir;
                  wrap_nx = step_wrap;
                  if (step_wrap) begin
                     pcnt_nx = pcnt + 8'd1;
                     if (cyc_r != 8'd0 && pcnt_nx == cyc_r) begin
                        state_nx = IDLE;
                        val_nx   = 8'd0;
                        presc_nx = '0;
                        done_nx  = 1'b1;
                     end
                  end
               end
               if (pause && state_nx == RUN) state_nx = PAUSE;
            end
         end
         PAUSE: begin
            if (stop) begin
               state_nx = IDLE;
               val_nx   = 8'd0;
               presc_nx = '0;
            end else if (start) begin
               state_nx = RUN;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         presc  <= '0;
         val    <= 8'd0;
         pcnt   <= 8'd0;
         dir_dn <= 1'b0;
         mode_r <= 2'b00;
         max_r  <= 8'hFF;
         cyc_r  <= 8'd0;
         wrap   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         presc  <= presc_nx;
         val    <= val_nx;
         pcnt   <= pcnt_nx;
         dir_dn <= dir_nx;
         mode_r <= mode_nx;
         max_r  <= max_nx;
         cyc_r  <= cyc_nx;
         wrap   <= wrap_nx;
         done   <= done_nx;
      end
   end

   assign busy      = (state != IDLE);
   assign cfg_ready = (state == IDLE);

endmodule

// File: doc/sawtooth_ctrl.md
SAWTOOTH_CTRL -- requirements
Module: sawtooth_ctrl

Interface
REQ-001 The block SHALL have parameter LEN, default 20, setting the number of clk cycles per value step (LEN >= 2).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low; the block is in reset while rst=0.
REQ-004 cfg_valid  input  1  configuration offered.
REQ-005 cfg_ready  output  1  configuration accepted this cycle if cfg_valid=1; equals (state==IDLE).
REQ-006 cfg_mode  input  2  waveform select: 00 saw-up, 01 saw-down, 10 triangle, 11 treated as saw-up.
REQ-007 cfg_max  input  8  peak value of the waveform.
REQ-008 cfg_cycles  input  8  number of periods to generate; 0 = continuous.
REQ-009 start  input  1  level-sampled: begin a run from IDLE, or resume from PAUSE.
REQ-010 pause  input  1  freeze the waveform while in RUN.
REQ-011 stop  input  1  abort to IDLE.
REQ-012 val  output  8  waveform value, registered.
REQ-013 busy  output  1  high in RUN and PAUSE.
REQ-014 wrap  output  1  one-cycle pulse at each period completion.
REQ-015 done  output  1  one-cycle pulse when the programmed period count completes.

Function
REQ-016 States SHALL be IDLE, RUN, PAUSE; the only transitions are IDLE->RUN (start), RUN->PAUSE (pause), PAUSE->RUN (start), RUN/PAUSE->IDLE (stop or count complete).
REQ-017 Config is latched into internal mode/max/cycles registers on cfg_valid&&cfg_ready; cfg inputs are ignored otherwise.
REQ-018 When cfg accept and start occur in the same IDLE cycle, the run SHALL use the newly accepted config.
REQ-019 On IDLE->RUN: prescaler=0, period count=0, val=0 for saw-up/triangle, val=max for saw-down, triangle direction=up.
REQ-020 Prescaler counts 0..LEN-1 in RUN only; a tick occurs in the cycle it equals LEN-1, then it wraps to 0; val updates on the edge ending the tick cycle.
REQ-021 Saw-up tick: val<max -> val+1; val==max -> val=0 and wrap.
REQ-022 Saw-down tick: val>0 -> val-1; val==0 -> val=max and wrap.
REQ-023 Triangle tick: up and val<max -> +1; up and val==max -> direction=down, val-1; down and val>0 -> -1; down and val==0 -> direction=up, val+1 and wrap.
REQ-024 max==0: val stays 0 and every tick is a wrap in all modes.
REQ-025 Triangle with max==1 SHALL alternate 0,1,0,1 with wrap on each 0->1 step.
REQ-026 Each wrap increments the 8-bit period count; when cycles!=0 and the count reaches cycles on that wrap, state->IDLE, val=0, done=1 for that cycle coincident with wrap=1.
REQ-027 cycles==0: the run never self-terminates; the period count wraps 255->0 silently.
REQ-028 In PAUSE, prescaler, val, direction and period count SHALL hold; no tick, wrap or done.
REQ-029 Priority within one cycle: stop > count-complete > pause > tick; stop in RUN/PAUSE -> IDLE with val=0 next cycle, no done pulse.
REQ-030 pause and tick in the same cycle: the tick step SHALL be taken, then PAUSE entered.
REQ-031 stop or pause in IDLE SHALL be ignored; start in RUN SHALL be ignored.
REQ-032 busy, cfg_ready SHALL be decoded from registered state only (no combinational input path).

Reset
REQ-033 While rst=0: state=IDLE, val=0, busy=0, wrap=0, done=0, cfg_ready=1, prescaler=0, period count=0, mode=00, max=8'hFF, cycles=0.
REQ-034 Reset asserted mid-run SHALL take effect immediately regardless of clk; after release the block waits in IDLE for start.

Verification
REQ-035 LEN=4, cfg saw-up max=3 cycles=2, start -> val 0,1,2,3,0,1,2,3 each held 4 clks; wrap at each 3->0; second wrap with done=1, then val=0, busy=0.
REQ-036 LEN=4, triangle max=2 cycles=1 -> val 0,1,2,1,0,1 sequence reaching done on the first 0->1 step after the down ramp; done and wrap coincide.
REQ-037 Saw-down max=5 cycles=0, pause after val=3 for 10 clks, then start -> val held at 3 with prescaler frozen; resumes 2,1,0,5 with no lost or extra clk.
REQ-038 Saw-up running, stop and pause asserted together -> next cycle IDLE, val=0, no done; cfg_ready=1.
REQ-039 cfg_valid with start in IDLE (max=7, mode=01) -> first val=7; cfg_valid asserted in RUN -> cfg_ready=0, latched max unchanged.
REQ-040 rst driven low between clk edges mid-run -> outputs reach reset values before the next edge; max==0 run afterwards shows wrap every LEN clks, val=0.
